// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a self-correcting one-hot priority token, a
// hold-limit forced release and a one-cycle dead gap between grants.
module ring_rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [N-1:0]         i_req,
  input  logic [N-1:0]         i_rel,
  output logic [N-1:0]         o_gnt,
  output logic                 o_gnt_valid,
  output logic [$clog2(N)-1:0] o_gnt_id,
  output logic [N-1:0]         o_ptr,
  output logic                 o_timeout,
  output logic                 o_err_fix
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_HOLD + 1) + 1;
  localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD);
  localparam logic [N-1:0]  PTR_RST  = N'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t          r_state;
  logic [N-1:0]    r_gnt;
  logic            r_gnt_valid;
  logic [IW-1:0]   r_gnt_id;
  logic [N-1:0]    r_ptr;
  logic [CW-1:0]   r_cnt;
  logic            r_timeout;
  logic            r_err_fix;

  logic [N-1:0]    w_ptr;
  logic            w_ptr_ok;
  logic [IW-1:0]   w_start;
  logic [IW-1:0]   w_idx;
  logic            w_found;
  logic [IW-1:0]   w_win;
  logic [N-1:0]    w_win_oh;
  logic [N-1:0]    w_rot;
  logic            w_req_g;
  logic            w_rel_g;
  logic            w_cnt_hit;
  logic            w_release;

  // All token consumers read through this net so a corrupted token is seen uniformly.
  assign w_ptr    = r_ptr;
  assign w_ptr_ok = (w_ptr != '0) && ((w_ptr & (w_ptr - 1'b1)) == '0);

  always_comb begin
    w_start = '0;
    if (w_ptr_ok) begin
      for (int i = 0; i < N; i++) begin
        if (w_ptr[i]) w_start = IW'(i);
      end
    end
  end

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = IW'((int'(w_start) + k) % N);
      if (!w_found && i_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_win_oh  = PTR_RST << w_win;
  assign w_rot     = {r_gnt[N-2:0], r_gnt[N-1]};
  assign w_req_g   = i_req[r_gnt_id];
  assign w_rel_g   = i_rel[r_gnt_id];
  assign w_cnt_hit = (MAX_HOLD != 0) && (r_cnt == HOLD_LIM);
  assign w_release = !w_req_g || w_rel_g || w_cnt_hit;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_id    <= '0;
      r_ptr       <= PTR_RST;
      r_cnt       <= '0;
      r_timeout   <= 1'b0;
      r_err_fix   <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      r_err_fix <= !w_ptr_ok;
      if (!w_ptr_ok) r_ptr <= PTR_RST;

      case (r_state)
        S_IDLE, S_GAP: begin
          if (w_found) begin
            r_gnt       <= w_win_oh;
            r_gnt_valid <= 1'b1;
            r_gnt_id    <= w_win;
            r_cnt       <= CW'(1);
            r_state     <= S_GRANT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_GRANT: begin
          if (w_release) begin
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_gnt_id    <= '0;
            r_cnt       <= '0;
            r_state     <= S_GAP;
            r_timeout   <= w_cnt_hit && w_req_g && !w_rel_g;
            // A token repair outranks the rotation.
            if (w_ptr_ok) r_ptr <= w_rot;
          end else if (r_cnt < HOLD_LIM) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_gnt       <= '0;
          r_gnt_valid <= 1'b0;
          r_gnt_id    <= '0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign o_gnt       = r_gnt;
  assign o_gnt_valid = r_gnt_valid;
  assign o_gnt_id    = r_gnt_id;
  assign o_ptr       = r_ptr;
  assign o_timeout   = r_timeout;
  assign o_err_fix   = r_err_fix;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Bench for ring_rr_arbiter: vector table, directed corner sequences and a
// randomized run against a behavioural owner/priority model.
module tb_ring_rr_arbiter;

  localparam int N  = 4;
  localparam int MH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] rel = '0;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic [3:0] ptr;
  logic       timeout;
  logic       err_fix;

  int n_checks = 0;
  int n_fail   = 0;

  ring_rr_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_req       (req),
    .i_rel       (rel),
    .o_gnt       (gnt),
    .o_gnt_valid (gnt_valid),
    .o_gnt_id    (gnt_id),
    .o_ptr       (ptr),
    .o_timeout   (timeout),
    .o_err_fix   (err_fix)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] rel;
    logic [3:0] gnt;
    logic [1:0] id;
    logic [3:0] ptr;
    logic       tmo;
  } vec_t;

  vec_t tbl[12];

  // Model: current owner (-1 = none), cycles held, priority start index.
  int   m_owner = -1;
  int   m_held  = 0;
  int   m_prio  = 0;
  logic m_tmo   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic bit_of(input logic [3:0] v, input int i);
    logic [1:0] s;
    s = i[1:0];
    return v[s];
  endfunction

  task automatic model_edge(input logic r, input logic [3:0] q, input logic [3:0] l);
    int cand;
    if (!r) begin
      m_owner = -1;
      m_held  = 0;
      m_prio  = 0;
      m_tmo   = 1'b0;
    end else begin
      m_tmo = 1'b0;
      if (m_owner >= 0) begin
        if (!bit_of(q, m_owner) || bit_of(l, m_owner) || m_held == MH) begin
          m_tmo   = bit_of(q, m_owner) && !bit_of(l, m_owner);
          m_prio  = (m_owner + 1) % N;
          m_owner = -1;
        end else begin
          m_held++;
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          cand = (m_prio + k) % N;
          if (m_owner < 0 && bit_of(q, cand)) begin
            m_owner = cand;
            m_held  = 1;
          end
        end
      end
    end
  endtask

  function automatic logic [12:0] exp_vec();
    logic [3:0] g;
    logic [3:0] p;
    logic [1:0] id;
    g  = '0;
    id = '0;
    p  = '0;
    if (m_owner >= 0) begin
      g[m_owner[1:0]] = 1'b1;
      id = m_owner[1:0];
    end
    p[m_prio[1:0]] = 1'b1;
    return {g, (m_owner >= 0), id, p, m_tmo, 1'b0};
  endfunction

  task automatic mstep();
    model_edge(rst_n, req, rel);
    step();
    check("model", {19'd0, gnt, gnt_valid, gnt_id, ptr, timeout, err_fix}, {19'd0, exp_vec()});
  endtask

  initial begin
    logic [3:0] eg;
    int tcount;

    tbl[0]  = '{1'b0, 4'hF, 4'h0, 4'h0, 2'd0, 4'h1, 1'b0};
    tbl[1]  = '{1'b0, 4'hF, 4'h0, 4'h0, 2'd0, 4'h1, 1'b0};
    tbl[2]  = '{1'b0, 4'hF, 4'h0, 4'h0, 2'd0, 4'h1, 1'b0};
    tbl[3]  = '{1'b1, 4'hF, 4'h0, 4'h1, 2'd0, 4'h1, 1'b0};
    tbl[4]  = '{1'b1, 4'hF, 4'h1, 4'h0, 2'd0, 4'h2, 1'b0};
    tbl[5]  = '{1'b1, 4'h0, 4'h0, 4'h0, 2'd0, 4'h2, 1'b0};
    tbl[6]  = '{1'b1, 4'h0, 4'h0, 4'h0, 2'd0, 4'h2, 1'b0};
    tbl[7]  = '{1'b1, 4'h4, 4'h0, 4'h4, 2'd2, 4'h2, 1'b0};
    tbl[8]  = '{1'b1, 4'h4, 4'h1, 4'h4, 2'd2, 4'h2, 1'b0};
    tbl[9]  = '{1'b1, 4'h4, 4'h0, 4'h4, 2'd2, 4'h2, 1'b0};
    tbl[10] = '{1'b1, 4'h4, 4'h4, 4'h0, 2'd0, 4'h8, 1'b0};
    tbl[11] = '{1'b1, 4'h0, 4'h0, 4'h0, 2'd0, 4'h8, 1'b0};

    #1;
    for (int i = 0; i < 12; i++) begin
      rst_n = tbl[i].rst_n;
      req   = tbl[i].req;
      rel   = tbl[i].rel;
      step();
      check("tbl_gnt",   gnt,       tbl[i].gnt);
      check("tbl_valid", gnt_valid, |tbl[i].gnt);
      check("tbl_id",    gnt_id,    tbl[i].id);
      check("tbl_ptr",   ptr,       tbl[i].ptr);
      check("tbl_tmo",   timeout,   tbl[i].tmo);
      check("tbl_err",   err_fix,   1'b0);
    end

    // Round-robin fairness with all requesters active
    rst_n = 1'b0; req = '0; rel = '0;
    step();
    rst_n = 1'b1; req = 4'hF;
    tcount = 0;
    for (int g = 0; g < 5; g++) begin
      eg = 4'b0001 << (g % 4);
      for (int c = 1; c <= MH; c++) begin
        step();
        check("rr_gnt", gnt, eg);
        if (timeout) tcount++;
      end
      step();
      check("rr_gap", gnt, 4'h0);
      check("rr_tmo", timeout, 1'b1);
      check("rr_ptr", ptr, {eg[2:0], eg[3]});
      if (timeout) tcount++;
    end
    check("rr_tmo_count", tcount, 5);

    // Timeout against release collision, then plain timeout
    rst_n = 1'b0; req = '0;
    step();
    rst_n = 1'b1; req = 4'h1;
    for (int c = 1; c <= MH; c++) step();
    check("col_held", gnt, 4'h1);
    rel = 4'h1;
    step();
    check("col_gnt", gnt, 4'h0);
    check("col_tmo", timeout, 1'b0);
    rel = 4'h0;
    for (int c = 1; c <= MH; c++) step();
    check("to_held", gnt, 4'h1);
    step();
    check("to_gnt", gnt, 4'h0);
    check("to_tmo", timeout, 1'b1);
    step();
    check("to_tmo_pulse", timeout, 1'b0);
    check("to_regrant", gnt, 4'h1);
    req = 4'h0;
    step();

    // Token corruption while idle
    rst_n = 1'b0; req = '0;
    step();
    rst_n = 1'b1;
    step();
    req = 4'b1100;
    force dut.w_ptr = 4'b0110;
    step();
    release dut.w_ptr;
    check("tok_err", err_fix, 1'b1);
    check("tok_ptr", ptr, 4'h1);
    check("tok_gnt", gnt, 4'b0100);
    check("tok_id",  gnt_id, 2'd2);
    step();
    check("tok_err_pulse", err_fix, 1'b0);

    // Reset in the 4th cycle of a grant
    rst_n = 1'b0; req = '0;
    step();
    rst_n = 1'b1; req = 4'b0010;
    step();
    check("mr_gnt1", gnt, 4'b0010);
    step(); step(); step();
    check("mr_gnt4", gnt, 4'b0010);
    rst_n = 1'b0;
    step();
    check("mr_gnt",   gnt, 4'h0);
    check("mr_valid", gnt_valid, 1'b0);
    check("mr_ptr",   ptr, 4'h1);
    check("mr_tmo",   timeout, 1'b0);
    rst_n = 1'b1;
    step();
    check("mr_regrant", gnt, 4'b0010);
    check("mr_tmo2",    timeout, 1'b0);

    // Randomized run against the model
    rst_n = 1'b0; req = '0; rel = '0;
    mstep();
    rst_n = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 9) == 0) req[b] = ~req[b];
      end
      rel = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
      mstep();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
